draw_scheduler: RTL and testbench

- Owns the single VGA plot port and shares it between three rectangle-fill requesters: erase old block (0), draw new block (1), HUD/score tile (2).
- Sits between gameplay_datapath/display logic and the VGA adapter.
- Fixed priority arbitration. Each granted request is rasterised one pixel per clock, with screen clipping and a freeze input.

---
 rtl/draw_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_draw_scheduler.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/draw_scheduler.sv
// Fixed-priority owner of the VGA plot port: serves three rectangle-fill requesters,
// rasterising each granted fill one pixel per clock with screen clipping and a freeze stall.
module draw_scheduler #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int DIM_BITS = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            req,
  input  logic [23:0]           req_x,
  input  logic [20:0]           req_y,
  input  logic [3*DIM_BITS-1:0] req_w,
  input  logic [3*DIM_BITS-1:0] req_h,
  input  logic [8:0]            req_colour,
  input  logic                  freeze,
  output logic [2:0]            grant,
  output logic [2:0]            done,
  output logic                  busy,
  output logic                  plot,
  output logic [7:0]            vga_x,
  output logic [6:0]            vga_y,
  output logic [2:0]            vga_colour
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAW, S_DONE} state_t;

  localparam logic [DIM_BITS-1:0] DIM_ONE = {{(DIM_BITS-1){1'b0}}, 1'b1};

  state_t              r_state;
  logic [1:0]          r_sel;
  logic [7:0]          r_x0;
  logic [6:0]          r_y0;
  logic [DIM_BITS-1:0] r_w;
  logic [DIM_BITS-1:0] r_h;
  logic [2:0]          r_colour;
  logic [DIM_BITS-1:0] r_cx;
  logic [DIM_BITS-1:0] r_cy;

  logic [1:0]          w_pick;
  logic [2:0]          w_sel_oh;
  logic [7:0]          w_in_x;
  logic [6:0]          w_in_y;
  logic [DIM_BITS-1:0] w_in_w;
  logic [DIM_BITS-1:0] w_in_h;
  logic [2:0]          w_in_c;
  logic [7:0]          w_org_x;
  logic [6:0]          w_org_y;
  logic [DIM_BITS-1:0] w_ncx;
  logic [DIM_BITS-1:0] w_ncy;
  logic                w_cx_end;
  logic                w_last;
  logic [8:0]          w_px;
  logic [7:0]          w_py;
  logic                w_inb;

  // Lowest set request index wins.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch can be inferred.
    w_pick = 2'd2;
    if (req[0])      w_pick = 2'd0;
    else if (req[1]) w_pick = 2'd1;
  end

  assign w_sel_oh = 3'b001 << r_sel;

  always_comb begin
    w_in_x = req_x[7:0];
    w_in_y = req_y[6:0];
    w_in_w = req_w[DIM_BITS-1:0];
    w_in_h = req_h[DIM_BITS-1:0];
    w_in_c = req_colour[2:0];
    case (r_sel)
      2'd1: begin
        w_in_x = req_x[15:8];
        w_in_y = req_y[13:7];
        w_in_w = req_w[2*DIM_BITS-1:DIM_BITS];
        w_in_h = req_h[2*DIM_BITS-1:DIM_BITS];
        w_in_c = req_colour[5:3];
      end
      2'd2: begin
        w_in_x = req_x[23:16];
        w_in_y = req_y[20:14];
        w_in_w = req_w[3*DIM_BITS-1:2*DIM_BITS];
        w_in_h = req_h[3*DIM_BITS-1:2*DIM_BITS];
        w_in_c = req_colour[8:6];
      end
      default: ;
    endcase
  end

  // Next pixel to issue: the origin comes straight from the requester in LOAD, from the latch afterwards.
  always_comb begin
    w_cx_end = (r_cx == r_w - DIM_ONE);
    w_last   = w_cx_end && (r_cy == r_h - DIM_ONE);
    w_org_x  = r_x0;
    w_org_y  = r_y0;
    w_ncx    = r_cx + DIM_ONE;
    w_ncy    = r_cy;
    if (r_state == S_LOAD) begin
      w_org_x = w_in_x;
      w_org_y = w_in_y;
      w_ncx   = '0;
      w_ncy   = '0;
    end else if (w_cx_end) begin
      w_ncx = '0;
      w_ncy = r_cy + DIM_ONE;
    end
    w_px  = {1'b0, w_org_x} + 9'(w_ncx);
    w_py  = {1'b0, w_org_y} + 8'(w_ncy);
    w_inb = (w_px < 9'(SCREEN_W)) && (w_py < 8'(SCREEN_H));
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_state    <= S_IDLE;
      r_sel      <= '0;
      r_x0       <= '0;
      r_y0       <= '0;
      r_w        <= '0;
      r_h        <= '0;
      r_colour   <= '0;
      r_cx       <= '0;
      r_cy       <= '0;
      grant      <= '0;
      done       <= '0;
      busy       <= 1'b0;
      plot       <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
    end else begin
      grant <= '0;
      done  <= '0;
      case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_sel   <= w_pick;
            grant   <= 3'b001 << w_pick;
            busy    <= 1'b1;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_x0     <= w_in_x;
          r_y0     <= w_in_y;
          r_w      <= w_in_w;
          r_h      <= w_in_h;
          r_colour <= w_in_c;
          r_cx     <= '0;
          r_cy     <= '0;
          if (w_in_w == '0 || w_in_h == '0) begin
            done    <= w_sel_oh;
            plot    <= 1'b0;
            r_state <= S_DONE;
          end else begin
            vga_x      <= w_px[7:0];
            vga_y      <= w_py[6:0];
            vga_colour <= w_in_c;
            plot       <= w_inb;
            r_state    <= S_DRAW;
          end
        end
        S_DRAW: begin
          if (freeze) begin
            plot <= 1'b0;
          end else if (w_last) begin
            done    <= w_sel_oh;
            plot    <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_cx       <= w_ncx;
            r_cy       <= w_ncy;
            vga_x      <= w_px[7:0];
            vga_y      <= w_py[6:0];
            vga_colour <= r_colour;
            plot       <= w_inb;
          end
        end
        S_DONE: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_draw_scheduler.sv
// Bench for draw_scheduler: table of fills, hand sequences for priority/freeze/reset,
// and random fills checked against a pixel-list model built from plain rectangle arithmetic.
module tb_draw_scheduler;
  localparam int DB = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    req;
  logic [23:0]   req_x;
  logic [20:0]   req_y;
  logic [3*DB-1:0] req_w;
  logic [3*DB-1:0] req_h;
  logic [8:0]    req_colour;
  logic          freeze;
  logic [2:0]    grant;
  logic [2:0]    done;
  logic          busy;
  logic          plot;
  logic [7:0]    vga_x;
  logic [6:0]    vga_y;
  logic [2:0]    vga_colour;

  always #5 clk = ~clk;

  draw_scheduler #(.SCREEN_W(160), .SCREEN_H(120), .DIM_BITS(DB)) dut (
    .clk(clk), .reset(reset), .req(req), .req_x(req_x), .req_y(req_y),
    .req_w(req_w), .req_h(req_h), .req_colour(req_colour), .freeze(freeze),
    .grant(grant), .done(done), .busy(busy), .plot(plot),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour)
  );

  typedef struct packed {logic [7:0] x; logic [6:0] y; logic [2:0] c;} pix_t;
  typedef struct {int cyc; logic [2:0] val;} ev_t;
  typedef struct {int idx; int x; int y; int w; int h; int c; int exp_plots; int exp_lat;} vec_t;

  pix_t pq[$];
  pix_t exp_q[$];
  ev_t  gq[$];
  ev_t  dq[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: sample just after the edge and log plots, grants and dones.
  task automatic tick();
    pix_t p;
    ev_t  e;
    @(posedge clk);
    #1;
    cyc++;
    if (plot === 1'b1) begin
      p = {vga_x, vga_y, vga_colour};
      pq.push_back(p);
    end
    if (grant !== 3'b000) begin
      e.cyc = cyc; e.val = grant; gq.push_back(e);
    end
    if (done !== 3'b000) begin
      e.cyc = cyc; e.val = done; dq.push_back(e);
    end
  endtask

  task automatic clear_q();
    pq.delete(); gq.delete(); dq.delete();
  endtask

  task automatic set_fields(input int idx, input int x, input int y, input int w, input int h, input int c);
    req_x[8*idx +: 8]      = 8'(x);
    req_y[7*idx +: 7]      = 7'(y);
    req_w[DB*idx +: DB]    = DB'(w);
    req_h[DB*idx +: DB]    = DB'(h);
    req_colour[3*idx +: 3] = 3'(c);
  endtask

  function automatic logic [25:0] all_outs();
    return {grant, done, busy, plot, vga_x, vga_y, vga_colour};
  endfunction

  // fmode: 0 no freeze, 1 random freeze, 2 freeze for flen cycles after the first pixel.
  task automatic run_fill(input string tag, input int idx, input int x, input int y, input int w,
                          input int h, input int c, input int fmode, input int flen,
                          input int exp_lat, input int exp_plots);
    int g = -1, exp_done = -1, prog = 0, fleft = 0, hold_chk = 0, req_cyc, first_bad;
    int wh = w * h;
    bit fstarted = 1'b0;
    pix_t p;
    exp_q.delete();
    for (int row = 0; row < h; row++)
      for (int col = 0; col < w; col++)
        if (x + col < 160 && y + row < 120) begin
          p = {8'(x + col), 7'(y + row), 3'(c)};
          exp_q.push_back(p);
        end
    clear_q();
    set_fields(idx, x, y, w, h, c);
    freeze  = 1'b0;
    req     = 3'b001 << idx;
    req_cyc = cyc;
    for (int t = 0; t < 4000; t++) begin
      tick();
      if (g < 0 && gq.size() > 0) begin
        g   = cyc;
        req = '0;
        if (wh == 0) exp_done = g + 1;
      end else if (g >= 0 && cyc == g + 1) begin
        req_x = 24'($urandom); req_y = 21'($urandom); req_w = 15'($urandom);
        req_h = 15'($urandom); req_colour = 9'($urandom);
      end
      if (hold_chk > 0) begin
        check({tag, "_freeze_hold"}, {16'd0, plot, vga_x, vga_y}, {16'd0, 1'b0, 8'(x), 7'(y)});
        hold_chk--;
      end
      if (dq.size() > 0) break;
      case (fmode)
        1: freeze = ($urandom_range(3) == 0);
        2: begin
          if (!fstarted && pq.size() == 1) begin
            fstarted = 1'b1; fleft = flen; hold_chk = flen;
          end
          freeze = (fleft > 0);
          if (fleft > 0) fleft--;
        end
        default: freeze = 1'b0;
      endcase
      if (g >= 0 && cyc >= g + 1 && exp_done < 0 && !freeze) begin
        prog++;
        if (prog == wh) exp_done = cyc + 1;
      end
    end
    freeze = 1'b0;
    check({tag, "_done_seen"}, dq.size(), 1);
    if (dq.size() > 0 && g >= 0) begin
      check({tag, "_grant_lat"}, g - req_cyc, 1);
      check({tag, "_grant_val"}, gq[0].val, 3'b001 << idx);
      check({tag, "_done_val"}, dq[0].val, 3'b001 << idx);
      check({tag, "_done_cycle"}, dq[0].cyc, exp_done);
      if (exp_lat >= 0) check({tag, "_done_lat"}, dq[0].cyc - g, exp_lat);
      if (exp_plots >= 0) check({tag, "_plots_table"}, pq.size(), exp_plots);
      check({tag, "_plots_model"}, pq.size(), exp_q.size());
      first_bad = exp_q.size();
      for (int i = 0; i < exp_q.size() && i < pq.size(); i++)
        if (pq[i] !== exp_q[i]) begin first_bad = i; break; end
      check({tag, "_first_bad_pixel"}, first_bad, exp_q.size());
      tick();
      check({tag, "_busy_after"}, busy, 1'b0);
    end
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{1,  20,  40,  2,  2, 4,   4,   5};
    vecs[1] = '{0, 158, 119,  4,  2, 3,   2,   9};
    vecs[2] = '{2,  50,  60,  0,  5, 7,   0,   1};
    vecs[3] = '{0,  10,  10,  5,  0, 1,   0,   1};
    vecs[4] = '{2,   0,   0,  1,  1, 5,   1,   2};
    vecs[5] = '{1, 159,   0,  3,  3, 2,   3,  10};
    vecs[6] = '{0, 150, 110, 31, 31, 6, 100, 962};
    vecs[7] = '{1, 255, 127,  2,  3, 1,   0,   7};
    vecs[8] = '{2,   0, 117, 31,  5, 3,  93, 156};

    reset = 1'b1; req = '0; freeze = 1'b0;
    req_x = '0; req_y = '0; req_w = '0; req_h = '0; req_colour = '0;
    tick(); tick();
    check("reset_outputs", {6'd0, all_outs()}, 32'd0);
    reset = 1'b0;
    tick(); tick();
    check("idle_no_req", {6'd0, all_outs()}, 32'd0);

    foreach (vecs[i])
      run_fill($sformatf("vec%0d", i), vecs[i].idx, vecs[i].x, vecs[i].y, vecs[i].w,
               vecs[i].h, vecs[i].c, 0, 0, vecs[i].exp_lat, vecs[i].exp_plots);

    run_fill("freeze", 0, 40, 50, 3, 1, 2, 2, 4, 8, 3);

    // Priority: all three at once, each requester drops its bit on its own grant.
    clear_q();
    for (int i = 0; i < 3; i++) set_fields(i, 10 + 2 * i, 5, 1, 1, i + 1);
    req = 3'b111;
    for (int t = 0; t < 60 && dq.size() < 3; t++) begin
      tick();
      if (grant !== 3'b000) req = req & ~grant;
    end
    tick();
    check("prio_grants", gq.size(), 3);
    check("prio_dones", dq.size(), 3);
    check("prio_plots", pq.size(), 3);
    if (gq.size() == 3 && dq.size() == 3 && pq.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("prio_grant%0d", i), gq[i].val, 3'b001 << i);
        check($sformatf("prio_done%0d", i), dq[i].val, 3'b001 << i);
        check($sformatf("prio_colour%0d", i), pq[i].c, 3'(i + 1));
      end
      check("prio_gap", gq[1].cyc - gq[0].cyc, 4);
    end

    // Reset mid-fill with the request still held high.
    clear_q();
    set_fields(0, 30, 30, 4, 4, 6);
    req = 3'b001;
    for (int t = 0; t < 40 && pq.size() < 5; t++) tick();
    reset = 1'b1;
    tick();
    check("midreset_outputs", {6'd0, all_outs()}, 32'd0);
    reset = 1'b0;
    tick();
    check("midreset_regrant", grant, 3'b001);
    check("midreset_no_done", dq.size(), 0);
    req = '0;
    for (int t = 0; t < 40 && dq.size() == 0; t++) tick();
    check("midreset_total_plots", pq.size(), 21);
    check("midreset_done", dq.size(), 1);
    tick();
    check("midreset_busy_after", busy, 1'b0);

    for (int i = 0; i < 30; i++) begin
      int rx, ry;
      rx = ($urandom_range(1) == 1) ? $urandom_range(255) : $urandom_range(170, 140);
      ry = ($urandom_range(1) == 1) ? $urandom_range(127) : $urandom_range(127, 110);
      run_fill($sformatf("rand%0d", i), $urandom_range(2), rx, ry, $urandom_range(12),
               $urandom_range(12), $urandom_range(7), $urandom_range(1), 0, -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
